// File: rtl/seq_detect_param_if.sv
// Bundles the serial data, configuration and status signals of seq_detect_param.
// The master drives stimulus and configuration; the slave (the detector) drives status.
interface seq_detect_param_if #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4,
    parameter int CNT_W = 8
);
    logic             x;
    logic             x_valid;
    logic             cfg_load;
    logic [PAT_W-1:0] pat;
    logic [LEN_W-1:0] pat_len;
    logic             overlap;
    logic             detect;
    logic             armed;
    logic             cfg_err;
    logic [CNT_W-1:0] match_cnt;

    modport master (
        output x, x_valid, cfg_load, pat, pat_len, overlap,
        input  detect, armed, cfg_err, match_cnt
    );

    modport slave (
        input  x, x_valid, cfg_load, pat, pat_len, overlap,
        output detect, armed, cfg_err, match_cnt
    );
endinterface

// File: rtl/seq_detect_param.sv
// Serial pattern detector with a runtime-loaded pattern, length and overlap mode.
// Define SEQDET_MATCH_CNT_EN to build the saturating match counter; otherwise match_cnt reads 0.
module seq_detect_param #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    seq_detect_param_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_e;

    localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(2);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PAT_W);

    state_e           state_q, state_d;
    logic [PAT_W-1:0] hist_q, hist_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] fill_q, fill_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             ovl_q, ovl_d;
    logic             detect_q, detect_d;
    logic             err_q, err_d;

    logic [PAT_W-1:0] hist_next;
    logic [PAT_W-1:0] len_mask;
    logic [LEN_W-1:0] fill_next;
    logic             cfg_legal;
    logic             accept;
    logic             hit;

    assign cfg_legal = (bus.pat_len >= MIN_LEN) && (bus.pat_len <= MAX_LEN);
    // A load in the same cycle wins over data, so that bit is never accepted.
    assign accept    = (state_q == RUN) && bus.x_valid && !bus.cfg_load;
    assign hist_next = {hist_q[PAT_W-2:0], bus.x};
    assign fill_next = (fill_q >= MAX_LEN) ? MAX_LEN : fill_q + LEN_W'(1);
    assign len_mask  = ~({PAT_W{1'b1}} << len_q);
    assign hit       = (fill_next >= len_q) && ((hist_next & len_mask) == (pat_q & len_mask));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            hist_q   <= '0;
            pat_q    <= '0;
            fill_q   <= '0;
            len_q    <= '0;
            ovl_q    <= 1'b0;
            detect_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            hist_q   <= hist_d;
            pat_q    <= pat_d;
            fill_q   <= fill_d;
            len_q    <= len_d;
            ovl_q    <= ovl_d;
            detect_q <= detect_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        hist_d   = hist_q;
        pat_d    = pat_q;
        fill_d   = fill_q;
        len_d    = len_q;
        ovl_d    = ovl_q;
        detect_d = 1'b0;
        err_d    = err_q;
        if (bus.cfg_load) begin
            if (cfg_legal) begin
                state_d = RUN;
                hist_d  = '0;
                fill_d  = '0;
                pat_d   = bus.pat;
                len_d   = bus.pat_len;
                ovl_d   = bus.overlap;
                err_d   = 1'b0;
            end else begin
                // Keep the old configuration so a later legal load is the only way back.
                state_d = IDLE;
                err_d   = 1'b1;
            end
        end else if (accept) begin
            hist_d   = hist_next;
            fill_d   = (hit && !ovl_q) ? '0 : fill_next;
            detect_d = hit;
        end
    end

    always_comb begin
        bus.detect  = detect_q;
        bus.armed   = (state_q == RUN);
        bus.cfg_err = err_q;
    end

`ifdef SEQDET_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (bus.cfg_load && cfg_legal) begin
            cnt_d = '0;
        end else if (accept && hit && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.match_cnt = cnt_q;
`else
    assign bus.match_cnt = '0;
`endif
endmodule
